// File: rtl/sync_debounce_edge_if.sv
// sync_debounce_edge_if: synchronized level in, debounced level and edge strobes out.
// Carries glitch_count only when SYNC_DEBOUNCE_GLITCH_CNT_EN is defined.
interface sync_debounce_edge_if;
  logic sync_in;
  logic debounced_out;
  logic rise_pulse;
  logic fall_pulse;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_count;
  modport master (output sync_in, input debounced_out, rise_pulse, fall_pulse, glitch_count);
  modport slave (input sync_in, output debounced_out, rise_pulse, fall_pulse, glitch_count);
`else
  modport master (output sync_in, input debounced_out, rise_pulse, fall_pulse);
  modport slave (input sync_in, output debounced_out, rise_pulse, fall_pulse);
`endif
endinterface

// File: rtl/sync_debounce_edge.sv
// sync_debounce_edge: accepts a level only after STABLE_CYCLES identical samples, with one-cycle edge strobes.
// Define SYNC_DEBOUNCE_GLITCH_CNT_EN to add a saturating count of rejected transitions.
module sync_debounce_edge #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_WIDTH = 4
) (
  input logic clk,
  input logic n_rst,
  sync_debounce_edge_if.slave bus
);
  typedef enum logic [1:0] {STABLE_LOW, CHK_HIGH, STABLE_HIGH, CHK_LOW} state_t;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic deb_q, deb_d, rise_q, rise_d, fall_q, fall_d, glitch;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= STABLE_LOW;
      cnt_q <= '0;
      deb_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      deb_q <= deb_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    deb_d = deb_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    glitch = 1'b0;
    case (state_q)
      STABLE_LOW: if (bus.sync_in) begin
        state_d = CHK_HIGH;
        cnt_d = CNT_WIDTH'(1);
      end
      CHK_HIGH: if (!bus.sync_in) begin
        state_d = STABLE_LOW;
        cnt_d = '0;
        glitch = 1'b1;
      end else if (cnt_q == LAST) begin
        state_d = STABLE_HIGH;
        cnt_d = '0;
        deb_d = 1'b1;
        rise_d = 1'b1;
      end else cnt_d = cnt_q + CNT_WIDTH'(1);
      STABLE_HIGH: if (!bus.sync_in) begin
        state_d = CHK_LOW;
        cnt_d = CNT_WIDTH'(1);
      end
      CHK_LOW: if (bus.sync_in) begin
        state_d = STABLE_HIGH;
        cnt_d = '0;
        glitch = 1'b1;
      end else if (cnt_q == LAST) begin
        state_d = STABLE_LOW;
        cnt_d = '0;
        deb_d = 1'b0;
        fall_d = 1'b1;
      end else cnt_d = cnt_q + CNT_WIDTH'(1);
    endcase
  end
  assign bus.debounced_out = deb_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_q;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) glitch_q <= '0;
    else if (glitch && glitch_q != 8'hff) glitch_q <= glitch_q + 8'd1;
  end
  assign bus.glitch_count = glitch_q;
`else
  logic unused_glitch;
  assign unused_glitch = glitch;
`endif
endmodule

// File: tb/tb_sync_debounce_edge.sv
// tb_sync_debounce_edge: random and directed stimulus scored against a run-length model of the debouncer.
module tb_sync_debounce_edge;
  localparam int SC = 4;
  typedef struct packed {
    logic deb;
    logic rise;
    logic fall;
    logic [7:0] gcnt;
  } exp_t;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int tests = 0;
  int fails = 0;
  exp_t sb[$];
  logic m_deb = 1'b0;
  int m_run = 0;
  int m_gcnt = 0;
  sync_debounce_edge_if bus();
  sync_debounce_edge #(.STABLE_CYCLES(SC), .CNT_WIDTH(4)) dut (.clk(clk), .n_rst(n_rst), .bus(bus.slave));
  always #5 clk = ~clk;
  initial begin
    #2ms;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end
  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask
  // Level is accepted once the run of samples differing from it reaches SC; a run cut short is a glitch.
  task automatic step(input logic v);
    exp_t e;
    bus.sync_in = v;
    @(posedge clk);
    #1;
    e = '0;
    if (v != m_deb) begin
      m_run++;
      if (m_run == SC) begin
        m_deb = v;
        m_run = 0;
        e.rise = v;
        e.fall = !v;
      end
    end else if (m_run > 0) begin
      m_run = 0;
      if (m_gcnt < 255) m_gcnt++;
    end
    e.deb = m_deb;
    e.gcnt = 8'(m_gcnt);
    sb.push_back(e);
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("debounced_out", int'(bus.debounced_out), int'(e.deb));
      check("rise_pulse", int'(bus.rise_pulse), int'(e.rise));
      check("fall_pulse", int'(bus.fall_pulse), int'(e.fall));
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
      check("glitch_count", int'(bus.glitch_count), int'(e.gcnt));
`endif
    end
  end
  task automatic apply_reset();
    @(negedge clk);
    #1;
    bus.sync_in = 1'b1;
    n_rst = 1'b0;
    #1;
    check("rst_debounced", int'(bus.debounced_out), 0);
    check("rst_rise", int'(bus.rise_pulse), 0);
    check("rst_fall", int'(bus.fall_pulse), 0);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    check("rst_glitch", int'(bus.glitch_count), 0);
`endif
    m_deb = 1'b0;
    m_run = 0;
    m_gcnt = 0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_hold_debounced", int'(bus.debounced_out), 0);
    check("rst_hold_rise", int'(bus.rise_pulse), 0);
    @(negedge clk);
    #1;
    n_rst = 1'b1;
  endtask
  task automatic run(input logic v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask
  initial begin
    bus.sync_in = 1'b1;
    apply_reset();
    run(1'b1, 6);
    run(1'b0, 4);
    run(1'b0, 2);
    run(1'b1, 3);
    run(1'b0, 3);
    for (int i = 0; i < 20; i++) step(1'(i % 2 == 0));
    for (int i = 0; i < 300; i++) begin
      step(1'b1);
      step(1'b0);
    end
    run(1'b1, 5);
    run(1'b0, 2);
    apply_reset();
    run(1'b1, 5);
    run(1'b0, 3);
    run(1'b1, 1);
    for (int i = 0; i < 400; i++) run(1'($urandom_range(0, 1)), $urandom_range(1, SC + 2));
    @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
